genius_game_core: RTL and testbench

- Single-clock controller for a "Genius" (Simon) memory game, merged with its sprite-flag decoder.
- Each round it appends a random colour to a stored sequence and plays the sequence back to the display.
- It then checks the player's button presses against the sequence, ending in win or lose.
- Two external timers are driven by START_1/START_2 and report expiry on END_1/END_2.

---
 rtl/genius_game_core_if.sv | 29 ++
 rtl/genius_game_core.sv | 183 ++++++++++++++++++
 tb/tb_genius_game_core.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/genius_game_core_if.sv
// Signal bundle between the Genius game core and its buttons, timers and video layer.
interface genius_game_core_if;
    logic       R;
    logic [2:0] B;
    logic [1:0] C;
    logic       END_1;
    logic       END_2;
    logic       START_1;
    logic       START_2;
    logic       VGA_FLAG;
    logic       VGA_LOSE;
    logic       VGA_WIN;
    logic [1:0] VGA;
    logic [3:0] estado_atual;
    logic [3:0] estado_futuro;
    logic [6:0] SPRITES_FLAGS;

    modport master (
        output R, B, C, END_1, END_2,
        input  START_1, START_2, VGA_FLAG, VGA_LOSE, VGA_WIN, VGA,
        input  estado_atual, estado_futuro, SPRITES_FLAGS
    );

    modport slave (
        input  R, B, C, END_1, END_2,
        output START_1, START_2, VGA_FLAG, VGA_LOSE, VGA_WIN, VGA,
        output estado_atual, estado_futuro, SPRITES_FLAGS
    );
endinterface

// File: rtl/genius_game_core.sv
// Genius (Simon) game controller: grows a random colour sequence, shows it,
// checks the player's presses against it, and drives the sprite enables.
module genius_game_core #(
    parameter int unsigned MAX_LEN   = 32,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic               CLK,
    input logic               RESET,
    genius_game_core_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MAX_LEN);
    localparam int unsigned LEN_W = IDX_W + 1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_ADD       = 4'd2,
        S_SHOW      = 4'd3,
        S_SHOW_WAIT = 4'd4,
        S_GAP       = 4'd5,
        S_ARM       = 4'd6,
        S_INPUT     = 4'd7,
        S_CHECK     = 4'd8,
        S_WIN       = 4'd9,
        S_LOSE      = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic             r_q;
    logic [7:0]       lfsr_q;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       seq_mem [MAX_LEN];

    logic             start_1_q, start_2_q, vga_flag_q, vga_lose_q, vga_win_q;
    logic [1:0]       vga_q;
    logic             start_1_d, start_2_d, vga_flag_d, vga_lose_d, vga_win_d;
    logic [1:0]       vga_d;

    logic             press, power_press, colour_press, colour_valid, last_idx;
    logic [1:0]       colour, seq_cur;
    logic [LEN_W-1:0] target;
    logic [6:0]       sprites;

    // Map button codes onto colour indices; anything else is not a colour.
    always_comb begin
        colour_valid = 1'b1;
        colour       = 2'd0;
        case (bus.B)
            3'd2:    colour = 2'd0;
            3'd3:    colour = 2'd1;
            3'd4:    colour = 2'd2;
            3'd6:    colour = 2'd3;
            default: colour_valid = 1'b0;
        endcase
    end

    assign press        = bus.R & ~r_q;
    assign power_press  = press & (bus.B == 3'd1);
    assign colour_press = press & colour_valid;
    assign seq_cur      = seq_mem[idx_q];
    assign last_idx     = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    assign target       = LEN_W'(4) << bus.C;

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a POWER press outside IDLE overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (power_press) state_d = S_START;
            S_START:     state_d = S_ADD;
            S_ADD:       state_d = S_SHOW;
            S_SHOW:      state_d = S_SHOW_WAIT;
            S_SHOW_WAIT: if (bus.END_1) state_d = last_idx ? S_ARM : S_GAP;
            S_GAP:       state_d = S_SHOW;
            S_ARM:       state_d = S_INPUT;
            S_INPUT: begin
                if (bus.END_2)
                    state_d = S_LOSE;
                else if (colour_press)
                    state_d = (colour != seq_cur) ? S_LOSE : (last_idx ? S_CHECK : S_INPUT);
            end
            S_CHECK:     state_d = (len_q == target) ? S_WIN : S_ADD;
            S_WIN:       state_d = S_WIN;
            S_LOSE:      state_d = S_LOSE;
            default:     state_d = S_IDLE;
        endcase
        if (power_press && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        start_1_d  = (state_d == S_SHOW);
        start_2_d  = (state_d == S_ARM) ||
                     ((state_q == S_INPUT) && (state_d == S_INPUT) && colour_press);
        vga_flag_d = (state_d == S_SHOW_WAIT);
        vga_lose_d = (state_d == S_LOSE);
        vga_win_d  = (state_d == S_WIN);
        vga_d      = vga_q;
        if (state_q == S_SHOW) vga_d = seq_cur;
        if (state_d == S_IDLE) vga_d = 2'd0;
    end

    // Output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            start_1_q  <= 1'b0;
            start_2_q  <= 1'b0;
            vga_flag_q <= 1'b0;
            vga_lose_q <= 1'b0;
            vga_win_q  <= 1'b0;
            vga_q      <= 2'd0;
        end else begin
            start_1_q  <= start_1_d;
            start_2_q  <= start_2_d;
            vga_flag_q <= vga_flag_d;
            vga_lose_q <= vga_lose_d;
            vga_win_q  <= vga_win_d;
            vga_q      <= vga_d;
        end
    end

    // Press history, free-running LFSR, sequence length and play/check index.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_q    <= 1'b0;
            lfsr_q <= LFSR_SEED;
            len_q  <= '0;
            idx_q  <= '0;
        end else begin
            r_q    <= bus.R;
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            case (state_q)
                S_START: begin
                    len_q <= '0;
                    idx_q <= '0;
                end
                S_ADD: begin
                    len_q <= len_q + LEN_W'(1);
                    idx_q <= '0;
                end
                S_SHOW_WAIT: begin
                    if (state_d == S_ARM)      idx_q <= '0;
                    else if (state_d == S_GAP) idx_q <= idx_q + IDX_W'(1);
                end
                S_INPUT: if ((state_d == S_INPUT) && colour_press) idx_q <= idx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Sequence memory: append the current random colour in ADD.
    always_ff @(posedge CLK) begin
        if (state_q == S_ADD) seq_mem[len_q[IDX_W-1:0]] <= lfsr_q[1:0];
    end

    // Sprite enables: shown colour wins, otherwise the colour on the buttons.
    always_comb begin
        sprites = '0;
        if (!RESET) begin
            if (vga_flag_q)        sprites[3:0] = 4'b0001 << vga_q;
            else if (colour_valid) sprites[3:0] = 4'b0001 << colour;
            sprites[4] = vga_lose_q;
            sprites[5] = vga_win_q;
            sprites[6] = (bus.B == 3'd1);
        end
    end

    assign bus.START_1       = start_1_q;
    assign bus.START_2       = start_2_q;
    assign bus.VGA_FLAG      = vga_flag_q;
    assign bus.VGA_LOSE      = vga_lose_q;
    assign bus.VGA_WIN       = vga_win_q;
    assign bus.VGA           = vga_q;
    assign bus.estado_atual  = state_q;
    assign bus.estado_futuro = state_d;
    assign bus.SPRITES_FLAGS = sprites;
endmodule

// File: tb/tb_genius_game_core.sv
// Directed bench for genius_game_core: a vector table for the first rounds and
// hand-written sequences for win, timeout, simultaneous events and async reset.
module tb_genius_game_core;
    logic CLK;
    logic RESET;

    genius_game_core_if bus ();

    genius_game_core #(.MAX_LEN(32), .LFSR_SEED(8'hA5)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference random generator and the colour sequence it should produce.
    logic [7:0] m_lfsr;
    logic [1:0] m_seq [32];
    int         m_len = 0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(posedge CLK) begin
        if (!RESET) begin
            if (bus.estado_atual == 4'd1) begin
                m_len <= 0;
            end else if ((bus.estado_atual == 4'd2) && (m_len < 32)) begin
                m_seq[m_len] <= m_lfsr[1:0];
                m_len        <= m_len + 1;
            end
        end
    end

    typedef struct {
        logic       r;
        logic [2:0] b;
        logic [1:0] c;
        logic       e1;
        logic       e2;
        logic [3:0] st;
        logic [4:0] flags;   // {START_1, START_2, VGA_FLAG, VGA_LOSE, VGA_WIN}
        logic       chk_vga;
        logic [1:0] vga;
        logic       chk_spr;
        logic [6:0] spr;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic r, input logic [2:0] b, input logic e1, input logic e2,
                                input logic [3:0] st, input logic [4:0] flags,
                                input logic chk_vga, input logic [1:0] vga,
                                input logic chk_spr, input logic [6:0] spr);
        vec_t v;
        v.r = r; v.b = b; v.c = 2'd0; v.e1 = e1; v.e2 = e2;
        v.st = st; v.flags = flags;
        v.chk_vga = chk_vga; v.vga = vga;
        v.chk_spr = chk_spr; v.spr = spr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.R = 1'b0; bus.B = 3'd0; bus.END_1 = 1'b0; bus.END_2 = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [3:0] s, input int budget);
        int n = 0;
        while ((bus.estado_atual !== s) && (n < budget)) begin
            step();
            n++;
        end
        check(name, 32'(bus.estado_atual), 32'(s));
    endtask

    task automatic press(input logic [2:0] code);
        bus.R = 1'b1; bus.B = code;
        step();
        bus.R = 1'b0; bus.B = 3'd0;
        step();
    endtask

    function automatic logic [2:0] code_of(input logic [1:0] col);
        case (col)
            2'd0:    return 3'd2;
            2'd1:    return 3'd3;
            2'd2:    return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    // Watch the whole show of an n-long sequence, then answer it correctly.
    task automatic play_round(input int n);
        for (int i = 0; i < n; i++) begin
            wait_state($sformatf("round%0d show%0d state", n, i), 4'd4, 20);
            check($sformatf("round%0d show%0d vga", n, i), 32'(bus.VGA), 32'(m_seq[i]));
            bus.END_1 = 1'b1;
            step();
            bus.END_1 = 1'b0;
        end
        wait_state($sformatf("round%0d input state", n), 4'd7, 10);
        for (int i = 0; i < n; i++) press(code_of(m_seq[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        //             r  b     e1 e2  st     S1S2FlLsWn chkv vga chks spr
        tbl[0]  = mk(1, 3'd1, 0, 0, 4'd1,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[1]  = mk(0, 3'd0, 0, 0, 4'd2,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[2]  = mk(0, 3'd0, 0, 0, 4'd3,  5'b10000, 0, 2'd0, 0, 7'b0000000);
        tbl[3]  = mk(0, 3'd0, 0, 0, 4'd4,  5'b00100, 1, 2'd1, 1, 7'b0000010);
        tbl[4]  = mk(0, 3'd0, 0, 1, 4'd4,  5'b00100, 0, 2'd0, 0, 7'b0000000);
        tbl[5]  = mk(0, 3'd0, 1, 0, 4'd6,  5'b01000, 0, 2'd0, 0, 7'b0000000);
        tbl[6]  = mk(0, 3'd0, 0, 0, 4'd7,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[7]  = mk(1, 3'd3, 0, 0, 4'd8,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[8]  = mk(1, 3'd3, 0, 0, 4'd2,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[9]  = mk(0, 3'd0, 0, 0, 4'd3,  5'b10000, 0, 2'd0, 0, 7'b0000000);
        tbl[10] = mk(0, 3'd0, 0, 0, 4'd4,  5'b00100, 1, 2'd1, 0, 7'b0000000);
        tbl[11] = mk(0, 3'd0, 1, 0, 4'd5,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[12] = mk(0, 3'd0, 0, 0, 4'd3,  5'b10000, 0, 2'd0, 0, 7'b0000000);
        tbl[13] = mk(0, 3'd0, 0, 0, 4'd4,  5'b00100, 1, 2'd1, 0, 7'b0000000);
        tbl[14] = mk(0, 3'd0, 1, 0, 4'd6,  5'b01000, 0, 2'd0, 0, 7'b0000000);
        tbl[15] = mk(0, 3'd0, 0, 0, 4'd7,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[16] = mk(0, 3'd0, 1, 0, 4'd7,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[17] = mk(1, 3'd5, 0, 0, 4'd7,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[18] = mk(0, 3'd0, 0, 0, 4'd7,  5'b00000, 0, 2'd0, 0, 7'b0000000);
        tbl[19] = mk(1, 3'd2, 0, 0, 4'd10, 5'b00010, 0, 2'd0, 1, 7'b0010001);
        tbl[20] = mk(0, 3'd0, 0, 0, 4'd10, 5'b00010, 0, 2'd0, 1, 7'b0010000);
        tbl[21] = mk(1, 3'd1, 0, 0, 4'd0,  5'b00000, 1, 2'd0, 1, 7'b1000000);
        tbl[22] = mk(0, 3'd0, 0, 0, 4'd0,  5'b00000, 0, 2'd0, 0, 7'b0000000);

        RESET = 1'b1;
        bus.C = 2'd0;
        idle_inputs();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("reset state", 32'(bus.estado_atual), 32'd0);
        check("reset outputs", 32'({bus.START_1, bus.START_2, bus.VGA_FLAG, bus.VGA_LOSE,
                                    bus.VGA_WIN, bus.VGA, bus.SPRITES_FLAGS}), 32'd0);
        RESET = 1'b0;

        // First two rounds, a wrong press, then POWER back to IDLE.
        for (int i = 0; i < NVEC; i++) begin
            bus.R = tbl[i].r; bus.B = tbl[i].b; bus.C = tbl[i].c;
            bus.END_1 = tbl[i].e1; bus.END_2 = tbl[i].e2;
            #1;
            if (i == 0) check("idle next state on power", 32'(bus.estado_futuro), 32'd1);
            step();
            check($sformatf("vec%0d state", i), 32'(bus.estado_atual), 32'(tbl[i].st));
            check($sformatf("vec%0d flags", i),
                  32'({bus.START_1, bus.START_2, bus.VGA_FLAG, bus.VGA_LOSE, bus.VGA_WIN}),
                  32'(tbl[i].flags));
            if (tbl[i].chk_vga) check($sformatf("vec%0d vga", i), 32'(bus.VGA), 32'(tbl[i].vga));
            if (tbl[i].chk_spr) check($sformatf("vec%0d sprites", i), 32'(bus.SPRITES_FLAGS), 32'(tbl[i].spr));
        end
        idle_inputs();

        // Four correct rounds at difficulty 0 reach WIN.
        bus.C = 2'd0;
        press(3'd1);
        for (int n = 1; n <= 4; n++) play_round(n);
        check("win state", 32'(bus.estado_atual), 32'd9);
        check("win flags", 32'({bus.VGA_WIN, bus.VGA_LOSE}), 32'b10);
        check("win sprites", 32'(bus.SPRITES_FLAGS), 32'b0100000);
        repeat (3) step();
        check("win holds", 32'(bus.estado_atual), 32'd9);

        // Input timeout loses.
        press(3'd1);
        check("power from win", 32'(bus.estado_atual), 32'd0);
        press(3'd1);
        wait_state("timeout show", 4'd4, 20);
        bus.END_1 = 1'b1; step(); bus.END_1 = 1'b0;
        wait_state("timeout input", 4'd7, 10);
        bus.END_2 = 1'b1; step(); bus.END_2 = 1'b0;
        check("timeout lose state", 32'(bus.estado_atual), 32'd10);
        check("timeout lose flag", 32'(bus.VGA_LOSE), 32'd1);

        // Timeout and a correct press together still lose.
        press(3'd1);
        press(3'd1);
        wait_state("race show", 4'd4, 20);
        bus.END_1 = 1'b1; step(); bus.END_1 = 1'b0;
        wait_state("race input", 4'd7, 10);
        bus.END_2 = 1'b1; bus.R = 1'b1; bus.B = code_of(m_seq[0]);
        step();
        idle_inputs();
        check("race lose state", 32'(bus.estado_atual), 32'd10);
        step();

        // Asynchronous reset in SHOW_WAIT clears everything at once.
        press(3'd1);
        press(3'd1);
        wait_state("areset show", 4'd4, 20);
        check("areset flag before", 32'(bus.VGA_FLAG), 32'd1);
        bus.B = 3'd6;
        #3;
        RESET = 1'b1;
        #1;
        check("areset state", 32'(bus.estado_atual), 32'd0);
        check("areset outputs", 32'({bus.START_1, bus.START_2, bus.VGA_FLAG, bus.VGA_LOSE,
                                     bus.VGA_WIN, bus.VGA, bus.estado_futuro}), 32'd0);
        check("areset sprites", 32'(bus.SPRITES_FLAGS), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("yellow sprite", 32'(bus.SPRITES_FLAGS), 32'b0001000);
        step();
        check("idle after reset", 32'(bus.estado_atual), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
